// File: rtl/ahb_lite_sram1rw.sv
// AHB3-Lite memory slave over a single-port, byte-addressable SRAM.
// Latency: zero wait states for legal transfers; illegal transfers get a two-cycle ERROR response.
// Backpressure: a write data phase stalls while HREADY=0; no transfer is accepted while HREADY=0.
//
// Ports:
//   HCLK, HRESETn           clock and synchronous active-high reset
//   HSEL/HADDR/HWRITE/...   AHB-Lite address phase (HBURST, HPROT ignored)
//   HWDATA                  write data, sampled when the write data phase completes
//   HREADY                  bus-level ready from the interconnect multiplexer
//   HREADYOUT/HRESP/HRDATA  registered slave response
module ahb_lite_sram1rw #(
  parameter int MEM_SIZE   = 1024,
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [HDATA_SIZE-1:0] HRDATA
);

  localparam int AW    = $clog2(MEM_SIZE);
  localparam int IW    = AW - 2;
  localparam int WORDS = MEM_SIZE / 4;
  localparam logic [HADDR_SIZE:0] MEM_LIMIT = (HADDR_SIZE + 1)'(MEM_SIZE);

  typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} err_state_t;

  logic [31:0] mem [WORDS];

  // Address-phase decode
  logic          accept;
  logic          in_range;
  logic          aligned;
  logic          legal;
  logic [IW-1:0] addr_idx;
  logic [3:0]    addr_be;

  // Registered data phase of the last accepted legal transfer
  logic          dp_vld;
  logic          dp_write;
  logic [IW-1:0] dp_idx;
  logic [3:0]    dp_be;

  logic          wr_fire;
  logic [31:0]   rd_word;
  err_state_t    err_state;

  logic          unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  always_comb begin
    accept   = HSEL & HREADY & HTRANS[1];
    in_range = ({1'b0, HADDR} < MEM_LIMIT);
    addr_idx = HADDR[AW-1:2];
    aligned  = 1'b0;
    addr_be  = 4'b1111;
    case (HSIZE)
      3'd0: begin
        aligned = 1'b1;
        addr_be = 4'b0001 << HADDR[1:0];
      end
      3'd1: begin
        aligned = ~HADDR[0];
        addr_be = HADDR[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        aligned = (HADDR[1:0] == 2'b00);
        addr_be = 4'b1111;
      end
      default: begin
        aligned = 1'b0;
        addr_be = 4'b1111;
      end
    endcase
    legal = in_range & aligned;
  end

  // A pending write commits on the edge where its data phase completes.
  assign wr_fire = dp_vld & dp_write & HREADY;

  // Read word with the in-flight write's bytes merged, so a read pipelined
  // directly behind a write to the same word sees the new data.
  always_comb begin
    rd_word = mem[addr_idx];
    for (int i = 0; i < 4; i++) begin
      if (wr_fire && (dp_idx == addr_idx) && dp_be[i]) begin
        rd_word[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  // Memory array carries no reset; a write pending at reset is dropped.
  always_ff @(posedge HCLK) begin
    if (!HRESETn && wr_fire) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_be[i]) begin
          mem[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      dp_vld    <= 1'b0;
      dp_write  <= 1'b0;
      dp_idx    <= '0;
      dp_be     <= '0;
      HRDATA    <= '0;
      err_state <= ST_OKAY;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
    end else begin
      // Data-phase pipeline advances only when the bus is ready.
      if (HREADY) begin
        dp_vld <= accept & legal;
        if (accept && legal) begin
          dp_write <= HWRITE;
          dp_idx   <= addr_idx;
          dp_be    <= addr_be;
          if (!HWRITE) begin
            HRDATA <= HDATA_SIZE'(rd_word);
          end
        end
      end

      // Two-cycle ERROR response: stall one cycle, then complete with ERROR.
      case (err_state)
        ST_ERR1: begin
          err_state <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        ST_ERR2: begin
          if (accept && !legal) begin
            err_state <= ST_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
          end else if (HREADY) begin
            err_state <= ST_OKAY;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
        default: begin
          if (accept && !legal) begin
            err_state <= ST_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= 1'b1;
          end else begin
            err_state <= ST_OKAY;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_sram1rw.sv
// Directed bench for ahb_lite_sram1rw: zero-wait reads/writes, byte lanes,
// forwarding, stalls, reset mid-transfer, ERROR sequences and SEQ bursts.
module tb_ahb_lite_sram1rw;
  localparam int MEM_SIZE = 1024;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  int n_checks = 0;
  int n_errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram1rw #(.MEM_SIZE(MEM_SIZE), .HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus(input logic sel, input logic [1:0] trans, input logic write,
                     input logic [2:0] size, input logic [31:0] addr);
    HSEL   = sel;
    HTRANS = trans;
    HWRITE = write;
    HSIZE  = size;
    HADDR  = addr;
  endtask

  task automatic idle();
    HSEL   = 1'b0;
    HTRANS = 2'd0;
    HWRITE = 1'b0;
  endtask

  task automatic write_x(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    bus(1'b1, 2'd2, 1'b1, size, addr);
    step();
    HWDATA = data;
    idle();
    check("wr_rdy", {31'd0, HREADYOUT}, 32'd1);
    check("wr_resp", {31'd0, HRESP}, 32'd0);
    step();
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus(1'b1, 2'd2, 1'b0, 3'd2, addr);
    step();
    idle();
    check(tag, HRDATA, exp);
    check({tag, "_resp"}, {31'd0, HRESP}, 32'd0);
  endtask

  // Illegal transfer; bench acts as the bus mux and drops HREADY during ERR1,
  // while offering a write to 0x48 that must not be accepted.
  task automatic err_seq(input string tag, input logic write, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] prev_rd);
    bus(1'b1, 2'd2, write, size, addr);
    step();
    HWDATA = 32'hFFFF_FFFF;
    HREADY = 1'b0;
    bus(1'b1, 2'd2, 1'b1, 3'd2, 32'h48);
    check({tag, "_e1_rdy"}, {31'd0, HREADYOUT}, 32'd0);
    check({tag, "_e1_resp"}, {31'd0, HRESP}, 32'd1);
    check({tag, "_e1_rdata"}, HRDATA, prev_rd);
    step();
    idle();
    HREADY = 1'b1;
    check({tag, "_e2_rdy"}, {31'd0, HREADYOUT}, 32'd1);
    check({tag, "_e2_resp"}, {31'd0, HRESP}, 32'd1);
    step();
    check({tag, "_ok_rdy"}, {31'd0, HREADYOUT}, 32'd1);
    check({tag, "_ok_resp"}, {31'd0, HRESP}, 32'd0);
    check({tag, "_ok_rdata"}, HRDATA, prev_rd);
  endtask

  logic [31:0] bd [4];

  initial begin
    HRESETn = 1'b1; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0;
    HSIZE = 3'd0; HBURST = 3'd0; HPROT = 4'd0; HTRANS = 2'd0; HREADY = 1'b1;
    bd[0] = 32'hA0A1A2A3; bd[1] = 32'hB0B1B2B3; bd[2] = 32'hC0C1C2C3; bd[3] = 32'hD0D1D2D3;

    step();
    step();
    check("rst_rdy", {31'd0, HREADYOUT}, 32'd1);
    check("rst_resp", {31'd0, HRESP}, 32'd0);
    check("rst_rdata", HRDATA, 32'd0);
    HRESETn = 1'b0;
    step();

    // Basic word write/read
    write_x(32'h10, 3'd2, 32'hDEADBEEF);
    read_check("t1_rd", 32'h10, 32'hDEADBEEF);
    check("t1_rdy", {31'd0, HREADYOUT}, 32'd1);

    // Byte and halfword lanes
    write_x(32'h20, 3'd2, 32'h11223344);
    write_x(32'h21, 3'd0, 32'h0000AA00);
    write_x(32'h22, 3'd1, 32'hBBCC0000);
    read_check("t2_lanes", 32'h20, 32'hBBCCAA44);

    // Read pipelined behind a write to the same word
    write_x(32'h30, 3'd2, 32'h12345678);
    bus(1'b1, 2'd2, 1'b1, 3'd2, 32'h30);
    step();
    HWDATA = 32'hCAFEF00D;
    bus(1'b1, 2'd2, 1'b0, 3'd2, 32'h30);
    step();
    idle();
    check("t3_fwd", HRDATA, 32'hCAFEF00D);
    bus(1'b1, 2'd2, 1'b1, 3'd0, 32'h31);
    step();
    HWDATA = 32'h0000EE00;
    bus(1'b1, 2'd2, 1'b0, 3'd2, 32'h30);
    step();
    idle();
    check("t3_fwd_byte", HRDATA, 32'hCAFEEE0D);
    read_check("t3_mem", 32'h30, 32'hCAFEEE0D);

    // Stalled write discarded by reset
    write_x(32'h40, 3'd2, 32'h55555555);
    bus(1'b1, 2'd2, 1'b1, 3'd2, 32'h40);
    step();
    HWDATA = 32'hA5A5A5A5;
    idle();
    HREADY = 1'b0;
    step();
    step();
    HRESETn = 1'b1;
    step();
    check("t4_rst_rdata", HRDATA, 32'd0);
    check("t4_rst_rdy", {31'd0, HREADYOUT}, 32'd1);
    HRESETn = 1'b0;
    HREADY = 1'b1;
    step();
    read_check("t4_discard", 32'h40, 32'h55555555);

    // Stalled write commits only the data present when HREADY returns
    bus(1'b1, 2'd2, 1'b1, 3'd2, 32'h44);
    step();
    HWDATA = 32'hFFFFFFFF;
    idle();
    HREADY = 1'b0;
    check("t4_stall_rdy", {31'd0, HREADYOUT}, 32'd1);
    step();
    HWDATA = 32'h12121212;
    step();
    HWDATA = 32'h0BADC0DE;
    HREADY = 1'b1;
    step();
    read_check("t4_stall", 32'h44, 32'h0BADC0DE);

    // IDLE/BUSY, unselected and HREADY-low cycles touch nothing
    HWDATA = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      bus(1'b1, 2'(i % 2), 1'b1, 3'd2, (i % 2 == 0) ? 32'h44 : 32'h40);
      step();
      check("t4_idle_resp", {30'd0, HREADYOUT, HRESP}, 32'd2);
    end
    bus(1'b0, 2'd2, 1'b1, 3'd2, 32'h44);
    step();
    HREADY = 1'b0;
    bus(1'b1, 2'd2, 1'b1, 3'd2, 32'h40);
    step();
    HREADY = 1'b1;
    idle();
    step();
    step();
    read_check("t4_untouched44", 32'h44, 32'h0BADC0DE);
    read_check("t4_untouched40", 32'h40, 32'h55555555);

    // ERROR responses
    write_x(32'h48, 3'd2, 32'h77777777);
    write_x(32'h00, 3'd2, 32'h13579BDF);
    err_seq("e_oob", 1'b0, 3'd2, MEM_SIZE, 32'h55555555);
    err_seq("e_mis", 1'b1, 3'd2, 32'h02, 32'h55555555);
    err_seq("e_size", 1'b0, 3'd3, 32'h08, 32'h55555555);
    err_seq("e_half", 1'b1, 3'd1, 32'h41, 32'h55555555);
    read_check("t5_wr_blocked", 32'h00, 32'h13579BDF);
    read_check("t5_err1_ignored", 32'h48, 32'h77777777);
    read_check("t5_half_blocked", 32'h40, 32'h55555555);

    // INCR4 write burst then read burst, no bubbles
    HBURST = 3'd3;
    for (int i = 0; i < 4; i++) begin
      bus(1'b1, (i == 0) ? 2'd2 : 2'd3, 1'b1, 3'd2, 32'h50 + 32'(4 * i));
      step();
      HWDATA = bd[i];
      check("t6_wr_rdy", {30'd0, HREADYOUT, HRESP}, 32'd2);
    end
    idle();
    step();
    for (int i = 0; i < 4; i++) begin
      bus(1'b1, (i == 0) ? 2'd2 : 2'd3, 1'b0, 3'd2, 32'h50 + 32'(4 * i));
      step();
      check("t6_rd_data", HRDATA, bd[i]);
      check("t6_rd_rdy", {30'd0, HREADYOUT, HRESP}, 32'd2);
    end
    idle();
    step();
    HBURST = 3'd0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
